// File: rtl/bram_logger_pkg.sv
// Shared definitions for the BRAM capture logger.
package bram_logger_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOG  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bram_logger.sv
// Streams valid samples into an external BRAM from address 0 upward until the
// memory is full or the capture is stopped, then serves random-access reads.
module bram_logger
    import bram_logger_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_run,
    input  logic                       i_stop,
    input  logic [BRAM_DATA_WIDTH-1:0] i_data,
    input  logic                       i_data_valid,
    input  logic                       i_rd_req,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_rd_addr,
    output logic [BRAM_DATA_WIDTH-1:0] o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_busy,
    output logic                       o_full,
    output logic [BRAM_ADDR_WIDTH:0]   o_count,
    output logic [BRAM_ADDR_WIDTH-1:0] addr,
    output logic                       chipselect_n,
    output logic                       write_n,
    output logic                       read_n,
    output logic [BRAM_DATA_WIDTH-1:0] bram_data_in,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_data_out
);

    state_e                       state_q, state_d;
    logic [BRAM_ADDR_WIDTH:0]     count_q, count_d;
    logic [BRAM_ADDR_WIDTH-1:0]   wr_ptr;
    logic [BRAM_ADDR_WIDTH-1:0]   addr_d;
    logic [BRAM_DATA_WIDTH-1:0]   din_d;
    logic                         cs_n_d, wr_n_d, rd_n_d;
    logic                         rd_acc;
    // Stage 0: read drive registered toward the BRAM; stage 1: BRAM data ready
    logic [1:0]                   rd_pipe_q;

    // The write pointer is always the count of words written so far
    assign wr_ptr = count_q[BRAM_ADDR_WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and next BRAM drive; address/data hold when idle to cut toggling
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cs_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        addr_d  = addr;
        din_d   = bram_data_in;
        rd_acc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_run) begin
                    state_d = LOG;
                    count_d = '0;
                end
            end
            LOG: begin
                if (i_data_valid) begin
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b0;
                    addr_d  = wr_ptr;
                    din_d   = i_data;
                    count_d = count_q + 1'b1;
                    // Last location written: stop rather than wrap
                    if (wr_ptr == {BRAM_ADDR_WIDTH{1'b1}}) state_d = DONE;
                end
                if (i_stop) state_d = DONE;
            end
            DONE: begin
                // A new capture takes priority; a same-cycle read is dropped
                if (i_run) begin
                    state_d = LOG;
                    count_d = '0;
                end else if (i_rd_req) begin
                    cs_n_d = 1'b0;
                    rd_n_d = 1'b0;
                    addr_d = i_rd_addr;
                    rd_acc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered BRAM port drive, word count and read-latency tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            chipselect_n <= 1'b1;
            write_n      <= 1'b1;
            read_n       <= 1'b1;
            addr         <= '0;
            bram_data_in <= '0;
            rd_pipe_q    <= '0;
        end else begin
            count_q      <= count_d;
            chipselect_n <= cs_n_d;
            write_n      <= wr_n_d;
            read_n       <= rd_n_d;
            addr         <= addr_d;
            bram_data_in <= din_d;
            rd_pipe_q    <= {rd_pipe_q[0], rd_acc};
        end
    end

    // BRAM output register is the data register; gate it so it reads 0 when invalid
    assign o_rd_valid = rd_pipe_q[1];
    assign o_rd_data  = rd_pipe_q[1] ? bram_data_out : '0;
    assign o_busy     = (state_q == LOG);
    assign o_full     = (state_q == DONE);
    assign o_count    = count_q;

endmodule

// File: tb/tb_bram_logger.sv
// Directed bench for bram_logger with a simple registered BRAM model attached.
module tb_bram_logger;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_run = 1'b0, i_stop = 1'b0, i_data_valid = 1'b0, i_rd_req = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [AW-1:0] i_rd_addr = '0;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_valid, o_busy, o_full;
    logic [AW:0]   o_count;
    logic [AW-1:0] addr;
    logic          chipselect_n, write_n, read_n;
    logic [DW-1:0] bram_data_in;
    logic [DW-1:0] bram_data_out = '0;
    logic [DW-1:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_logger #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_stop(i_stop),
        .i_data(i_data), .i_data_valid(i_data_valid),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_busy(o_busy), .o_full(o_full), .o_count(o_count),
        .addr(addr), .chipselect_n(chipselect_n), .write_n(write_n),
        .read_n(read_n), .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
    );

    // Registered-output BRAM model; contents survive reset
    always @(posedge clk) begin
        if (!chipselect_n) begin
            if (!write_n) mem[addr] <= bram_data_in;
            if (!read_n)  bram_data_out <= mem[addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated read: data must appear exactly two cycles after the request
    task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        i_rd_req = 1'b1; i_rd_addr = a;
        tick();
        i_rd_req = 1'b0;
        chk("rd_n_low", read_n, 1'b0);
        chk("rd_vld_early", o_rd_valid, 1'b0);
        tick();
        chk("rd_vld", o_rd_valid, 1'b1);
        chk($sformatf("rd_data[%0d]", a), o_rd_data, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_full"}, o_full, 1'b0);
        chk({tag, "_count"}, o_count, 0);
        chk({tag, "_vld"}, o_rd_valid, 1'b0);
        chk({tag, "_rdata"}, o_rd_data, 0);
        chk({tag, "_ctl"}, {chipselect_n, write_n, read_n}, 3'b111);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_din"}, bram_data_in, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        #12;
        chk_reset_outs("rst");
        tick();
        rst_n = 1'b1;

        // Reads in IDLE are ignored
        i_rd_req = 1'b1; i_rd_addr = 4'd3;
        tick(); chk("idle_rd_n", read_n, 1'b1);
        tick(); chk("idle_rd_vld", o_rd_valid, 1'b0);
        i_rd_req = 1'b0;

        // Full capture of 16 samples
        i_run = 1'b1; tick(); i_run = 1'b0;
        chk("run_busy", o_busy, 1'b1);
        chk("run_count", o_count, 0);
        for (int i = 0; i < 16; i++) begin
            i_data = 16'h0100 + 16'(i); i_data_valid = 1'b1;
            tick();
            chk("fill_wr_n", write_n, 1'b0);
            chk("fill_addr", addr, i);
            chk("fill_din", bram_data_in, 32'h0100 + i);
        end
        i_data_valid = 1'b0;
        chk("fill_full", o_full, 1'b1);
        chk("fill_busy", o_busy, 1'b0);
        chk("fill_count", o_count, 16);
        for (int i = 0; i < 16; i++) rd_chk(4'(i), 16'h0100 + 16'(i));
        tick(); chk("rd_vld_drop", o_rd_valid, 1'b0);

        // Gapped capture stopped on the 5th sample
        i_run = 1'b1; tick(); i_run = 1'b0;
        chk("run2_count", o_count, 0);
        begin
            logic [8:0] pat;
            int k;
            pat = 9'b1_0100_1101;   // bit j = valid in cycle j (LSB first)
            k = 0;
            for (int j = 0; j < 9; j++) begin
                i_data_valid = pat[j];
                i_data = 16'h0200 + 16'(k);
                i_stop = (j == 8);
                tick();
                if (pat[j]) k++;
            end
        end
        i_data_valid = 1'b0; i_stop = 1'b0;
        chk("stop_full", o_full, 1'b1);
        chk("stop_count", o_count, 5);
        i_data = 16'hDEAD; i_data_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("done_no_wr", write_n, 1'b1);
        end
        i_data_valid = 1'b0;
        rd_chk(4'd4, 16'h0204);
        rd_chk(4'd5, 16'h0105);   // beyond count: stale data from first capture

        // Back-to-back reads 3, 7, 1
        tick();
        i_rd_req = 1'b1; i_rd_addr = 4'd3; tick();
        chk("b2b_vld0", o_rd_valid, 1'b0);
        i_rd_addr = 4'd7; tick();
        chk("b2b_vld1", o_rd_valid, 1'b1); chk("b2b_d3", o_rd_data, 16'h0203);
        i_rd_addr = 4'd1; tick();
        chk("b2b_vld2", o_rd_valid, 1'b1); chk("b2b_d7", o_rd_data, 16'h0107);
        i_rd_req = 1'b0; tick();
        chk("b2b_vld3", o_rd_valid, 1'b1); chk("b2b_d1", o_rd_data, 16'h0201);
        tick();
        chk("b2b_vld4", o_rd_valid, 1'b0);

        // In-flight read completes; read issued with i_run is dropped
        i_rd_req = 1'b1; i_rd_addr = 4'd0; tick();
        i_run = 1'b1; i_rd_addr = 4'd2; tick();
        i_run = 1'b0; i_rd_req = 1'b0;
        chk("runrd_busy", o_busy, 1'b1);
        chk("runrd_count", o_count, 0);
        chk("runrd_rd_n", read_n, 1'b1);
        chk("inflight_vld", o_rd_valid, 1'b1);
        chk("inflight_data", o_rd_data, 16'h0200);
        tick(); chk("dropped_vld", o_rd_valid, 1'b0);

        // Reads during LOG are ignored
        i_rd_req = 1'b1; i_rd_addr = 4'd9;
        tick(); chk("log_rd_n", read_n, 1'b1);
        tick(); chk("log_rd_vld", o_rd_valid, 1'b0);
        i_rd_req = 1'b0;

        // Reset in the middle of a capture
        for (int i = 0; i < 8; i++) begin
            i_data = 16'h0300 + 16'(i); i_data_valid = 1'b1;
            tick();
        end
        i_data_valid = 1'b0;
        chk("pre_rst_count", o_count, 8);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("arst");
        tick();
        rst_n = 1'b1;
        i_run = 1'b1; tick(); i_run = 1'b0;
        i_stop = 1'b1; tick(); i_stop = 1'b0;
        chk("rst_stop_full", o_full, 1'b1);
        chk("rst_stop_count", o_count, 0);
        for (int i = 0; i < 7; i++) rd_chk(4'(i), 16'h0300 + 16'(i));
        for (int i = 8; i < 16; i++) rd_chk(4'(i), 16'h0100 + 16'(i));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
